byte_striping: RTL and testbench



---
 rtl/byte_striping.sv | 113 +++++++++++
 tb/tb_byte_striping.sv | 114 +++++++++++
 2 files changed

// File: rtl/byte_striping.sv
// Byte striper for the transmit path: broadcasts ordered-set symbols to all
// four lanes outside a packet and deals packet bytes (STP..END) round-robin
// across TL0..TL3, starting at lane 0.
module byte_striping #(
   parameter logic [7:0] SKP = 8'h1C,
   parameter logic [7:0] IDL = 8'h7C,
   parameter logic [7:0] STP = 8'hFB,
   parameter logic [7:0] END = 8'hFD
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic [7:0] fromMux,
   output logic [7:0] TL0,
   output logic [7:0] TL1,
   output logic [7:0] TL2,
   output logic [7:0] TL3,
   output logic [3:0] laneValid
);

   typedef enum logic {
      OUTSIDE = 1'b0,
      INPKT   = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [1:0]      ptr_q, ptr_d;
   logic [3:0][7:0] lane_q, lane_d;
   logic [3:0]      lane_valid_q, lane_valid_d;
   logic [3:0]      wr_en;

   logic is_ordered_set;
   logic is_stp;
   logic is_end;

   assign is_ordered_set = (fromMux == SKP) || (fromMux == IDL);
   assign is_stp         = (fromMux == STP);
   assign is_end         = (fromMux == END);

   // State, lane pointer and lane output registers; synchronous reset aborts any packet in flight.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q      <= OUTSIDE;
         ptr_q        <= 2'd0;
         lane_q       <= '0;
         lane_valid_q <= 4'b0000;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         lane_q       <= lane_d;
         lane_valid_q <= lane_valid_d;
      end
   end

   // Next state and lane pointer: STP opens a packet with lane 0 already used, END closes it.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      case (state_q)
         OUTSIDE: begin
            if (is_ordered_set) begin
               ptr_d = 2'd0;
            end else if (is_stp) begin
               state_d = INPKT;
               ptr_d   = 2'd1;
            end
         end
         INPKT: begin
            if (is_end) begin
               state_d = OUTSIDE;
               ptr_d   = 2'd0;
            end else begin
               ptr_d = ptr_q + 2'd1;
            end
         end
         default: begin
            state_d = OUTSIDE;
            ptr_d   = 2'd0;
         end
      endcase
   end

   // Lane write enables: broadcast for ordered sets, lane 0 for STP, one-hot at ptr inside a packet.
   always_comb begin
      wr_en = 4'b0000;
      case (state_q)
         OUTSIDE: begin
            if (is_ordered_set) begin
               wr_en = 4'b1111;
            end else if (is_stp) begin
               wr_en = 4'b0001;
            end
         end
         INPKT: begin
            wr_en = 4'b0001 << ptr_q;
         end
         default: begin
            wr_en = 4'b0000;
         end
      endcase

      lane_valid_d = wr_en;
      for (int n = 0; n < 4; n++) begin
         lane_d[n] = wr_en[n] ? fromMux : lane_q[n];
      end
   end

   assign TL0       = lane_q[0];
   assign TL1       = lane_q[1];
   assign TL2       = lane_q[2];
   assign TL3       = lane_q[3];
   assign laneValid = lane_valid_q;

endmodule

// File: tb/tb_byte_striping.sv
// Directed bench for byte_striping: each step drives one byte, clocks once,
// and compares the four lanes and laneValid against hand-computed values.
module tb_byte_striping;

   logic       clk;
   logic       reset_L;
   logic [7:0] fromMux;
   logic [7:0] TL0, TL1, TL2, TL3;
   logic [3:0] laneValid;

   int checkCount = 0;
   int passCount  = 0;

   byte_striping dut (
      .clk       (clk),
      .reset_L   (reset_L),
      .fromMux   (fromMux),
      .TL0       (TL0),
      .TL1       (TL1),
      .TL2       (TL2),
      .TL3       (TL3),
      .laneValid (laneValid)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Compare one observed value with its expected value and report a miss.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   // Drive one byte with the given reset level, clock it in, sample just after the edge.
   task automatic applyStimulus(input logic rstL, input logic [7:0] din);
      reset_L = rstL;
      fromMux = din;
      @(posedge clk);
      #1;
   endtask

   // One directed vector: lanes packed as {TL0,TL1,TL2,TL3}.
   task automatic step(input string tag, input logic rstL, input logic [7:0] din,
                       input logic [31:0] expLanes, input logic [3:0] expValid);
      applyStimulus(rstL, din);
      checkOutput({tag, " lanes"}, {TL0, TL1, TL2, TL3}, expLanes);
      checkOutput({tag, " valid"}, {28'd0, laneValid}, {28'd0, expValid});
   endtask

   // Directed sequence following the bring-up plan plus a few extra boundary cases.
   initial begin
      reset_L = 1'b0;
      fromMux = 8'h00;

      // Reset held for two edges.
      applyStimulus(1'b0, 8'h00);
      step("reset",        1'b0, 8'h00, 32'h00000000, 4'b0000);

      // Non-control bytes outside a packet are ignored.
      step("idle55_a",     1'b1, 8'h55, 32'h00000000, 4'b0000);
      step("idle55_b",     1'b1, 8'h55, 32'h00000000, 4'b0000);

      // SKP and IDL broadcast.
      step("skp_a",        1'b1, 8'h1C, 32'h1C1C1C1C, 4'b1111);
      step("skp_b",        1'b1, 8'h1C, 32'h1C1C1C1C, 4'b1111);
      step("skp_c",        1'b1, 8'h1C, 32'h1C1C1C1C, 4'b1111);
      step("idl_a",        1'b1, 8'h7C, 32'h7C7C7C7C, 4'b1111);
      step("idl_b",        1'b1, 8'h7C, 32'h7C7C7C7C, 4'b1111);
      step("idl_c",        1'b1, 8'h7C, 32'h7C7C7C7C, 4'b1111);

      // Packet: STP, six data bytes wrapping past lane 3, END on lane 3.
      step("pkt_stp",      1'b1, 8'hFB, 32'hFB7C7C7C, 4'b0001);
      step("pkt_d1",       1'b1, 8'hFF, 32'hFBFF7C7C, 4'b0010);
      step("pkt_d2",       1'b1, 8'hFF, 32'hFBFFFF7C, 4'b0100);
      step("pkt_d3",       1'b1, 8'hFF, 32'hFBFFFFFF, 4'b1000);
      step("pkt_d4",       1'b1, 8'hFF, 32'hFFFFFFFF, 4'b0001);
      step("pkt_d5",       1'b1, 8'hFF, 32'hFFFFFFFF, 4'b0010);
      step("pkt_d6",       1'b1, 8'hFF, 32'hFFFFFFFF, 4'b0100);
      step("pkt_end",      1'b1, 8'hFD, 32'hFFFFFFFD, 4'b1000);

      // Back to broadcast right after END.
      step("post_idl",     1'b1, 8'h7C, 32'h7C7C7C7C, 4'b1111);

      // Control codes inside a packet are plain data.
      step("ctl_stp",      1'b1, 8'hFB, 32'hFB7C7C7C, 4'b0001);
      step("ctl_skp",      1'b1, 8'h1C, 32'hFB1C7C7C, 4'b0010);
      step("ctl_idl",      1'b1, 8'h7C, 32'hFB1C7C7C, 4'b0100);
      step("ctl_stp2",     1'b1, 8'hFB, 32'hFB1C7CFB, 1000 == 0 ? 4'b0000 : 4'b1000);
      step("ctl_end",      1'b1, 8'hFD, 32'hFD1C7CFB, 4'b0001);

      // Data and a stray END outside a packet do nothing.
      step("out_data",     1'b1, 8'h55, 32'hFD1C7CFB, 4'b0000);
      step("out_end",      1'b1, 8'hFD, 32'hFD1C7CFB, 4'b0000);

      // Reset in the middle of a packet, then a fresh packet starts at lane 0.
      step("mid_stp",      1'b1, 8'hFB, 32'hFB1C7CFB, 4'b0001);
      step("mid_d1",       1'b1, 8'hFF, 32'hFBFF7CFB, 4'b0010);
      step("mid_reset",    1'b0, 8'hFF, 32'h00000000, 4'b0000);
      step("new_stp",      1'b1, 8'hFB, 32'hFB000000, 4'b0001);
      step("new_d1",       1'b1, 8'hFF, 32'hFBFF0000, 4'b0010);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
